// File: rtl/mso_trigger_capture_if.sv
// mso_trigger_capture_if: sample stream, trigger control
// and readback port bundle for the MSO capture block.
interface mso_trigger_capture_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10
);
  logic                         sample_valid;
  logic signed [DATA_WIDTH-1:0] sample_in;
  logic                         arm;
  logic signed [DATA_WIDTH-1:0] trig_level;
  logic                         trig_rising;
  logic                         force_trig;
  logic [DEPTH_LOG2-1:0]        pretrig;
  logic                         rd_en;
  logic signed [DATA_WIDTH-1:0] rd_data;
  logic                         rd_valid;
  logic                         busy;
  logic                         triggered;
  logic                         done;

  modport master (
    output sample_valid, sample_in, arm,
    output trig_level, trig_rising,
    output force_trig, pretrig, rd_en,
    input  rd_data, rd_valid,
    input  busy, triggered, done
  );

  modport slave (
    input  sample_valid, sample_in, arm,
    input  trig_level, trig_rising,
    input  force_trig, pretrig, rd_en,
    output rd_data, rd_valid,
    output busy, triggered, done
  );
endinterface

// File: rtl/mso_trigger_capture.sv
// mso_trigger_capture: edge trigger on the decimated stream,
// pre/post window in a circular RAM, oldest-first readback.
module mso_trigger_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enabled,
  mso_trigger_capture_if.slave  bus
);

  localparam int N = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] N_W =
    (DEPTH_LOG2+1)'(N);
  localparam logic [DEPTH_LOG2:0] ONE_W =
    (DEPTH_LOG2+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [DATA_WIDTH-1:0] mem [N];

  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2-1:0] t_addr;
  logic [DEPTH_LOG2-1:0] p_r;
  logic [DEPTH_LOG2:0]   cnt;
  logic [DEPTH_LOG2:0]   cnt_inc;
  logic [DEPTH_LOG2:0]   post_len;
  logic [DEPTH_LOG2:0]   rd_cnt;

  logic signed [DATA_WIDTH-1:0] prev;
  logic signed [DATA_WIDTH-1:0] smp;
  logic signed [DATA_WIDTH-1:0] lvl;
  logic [DATA_WIDTH-1:0]        rd_data_r;

  logic prev_valid;
  logic force_lat;
  logic trig_r;
  logic done_r;
  logic rd_valid_r;

  logic capturing;
  logic acc;
  logic edge_hit;
  logic start;
  logic trig_hit;
  logic go_done;
  logic rd_fire;

  assign smp = bus.sample_in;
  assign lvl = bus.trig_level;

  // Next state plus the one-cycle control strobes
  // that steer the datapath registers.
  always_comb begin
    state_n   = state;
    start     = 1'b0;
    trig_hit  = 1'b0;
    go_done   = 1'b0;
    rd_fire   = 1'b0;
    edge_hit  = 1'b0;
    capturing = (state == S_PRE) ||
                (state == S_WAIT) ||
                (state == S_POST);
    acc       = enabled && bus.sample_valid &&
                capturing;
    cnt_inc   = cnt + ONE_W;
    post_len  = N_W - {1'b0, p_r};
    if (bus.trig_rising) begin
      edge_hit = prev_valid && (prev < lvl) &&
                 (smp >= lvl);
    end else begin
      edge_hit = prev_valid && (prev > lvl) &&
                 (smp <= lvl);
    end
    if (enabled) begin
      unique case (state)
        S_IDLE: begin
          if (bus.arm) begin
            start = 1'b1;
            // pretrig is DEPTH_LOG2 bits, so it
            // can never exceed N-1 on its own
            if (bus.pretrig == '0) begin
              state_n = S_WAIT;
            end else begin
              state_n = S_PRE;
            end
          end
        end
        S_PRE: begin
          if (acc && cnt_inc == {1'b0, p_r}) begin
            state_n = S_WAIT;
          end
        end
        S_WAIT: begin
          if (acc && (edge_hit || force_lat ||
                      bus.force_trig)) begin
            trig_hit = 1'b1;
            // P = N-1 leaves room only for the
            // trigger sample itself
            if (post_len == ONE_W) begin
              go_done = 1'b1;
              state_n = S_DONE;
            end else begin
              state_n = S_POST;
            end
          end
        end
        S_POST: begin
          if (acc && cnt_inc == post_len) begin
            go_done = 1'b1;
            state_n = S_DONE;
          end
        end
        S_DONE: begin
          if (bus.rd_en && rd_cnt != N_W) begin
            rd_fire = 1'b1;
            if (rd_cnt == N_W - ONE_W) begin
              state_n = S_IDLE;
            end
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Sample RAM write port; no reset so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wp] <= smp;
    end
  end

  // Pointers, counters, trigger latches and registered readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp         <= '0;
      rp         <= '0;
      t_addr     <= '0;
      p_r        <= '0;
      cnt        <= '0;
      rd_cnt     <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      force_lat  <= 1'b0;
      trig_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else if (enabled) begin
      rd_valid_r <= rd_fire;
      if (rd_fire) begin
        rd_data_r <= mem[rp];
        rp        <= rp + 1'b1;
        rd_cnt    <= rd_cnt + ONE_W;
      end
      if (state == S_IDLE && rd_valid_r) begin
        done_r <= 1'b0;
        trig_r <= 1'b0;
      end
      if (start) begin
        wp         <= '0;
        cnt        <= '0;
        rd_cnt     <= '0;
        prev_valid <= 1'b0;
        force_lat  <= 1'b0;
        p_r        <= bus.pretrig;
        trig_r     <= 1'b0;
        done_r     <= 1'b0;
      end
      if (acc) begin
        wp         <= wp + 1'b1;
        prev       <= smp;
        prev_valid <= 1'b1;
        cnt        <= cnt_inc;
      end
      if (state == S_WAIT && bus.force_trig) begin
        force_lat <= 1'b1;
      end
      if (trig_hit) begin
        t_addr    <= wp;
        cnt       <= ONE_W;
        trig_r    <= 1'b1;
        force_lat <= 1'b0;
      end
      if (go_done) begin
        done_r <= 1'b1;
        // oldest sample of the window: P before T
        if (trig_hit) begin
          rp <= wp - p_r;
        end else begin
          rp <= t_addr - p_r;
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.busy      = capturing;
  assign bus.triggered = trig_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_mso_trigger_capture.sv
// tb_mso_trigger_capture: directed checks of trigger,
// window placement, readback order and control corners.
module tb_mso_trigger_capture;

  logic clk;
  logic rst_n;
  logic enabled;

  int n_chk;
  int n_fail;
  int exp_w [16];
  logic trig_w;

  mso_trigger_capture_if #(
    .DATA_WIDTH(16),
    .DEPTH_LOG2(4)
  ) bus ();

  mso_trigger_capture #(
    .DATA_WIDTH(16),
    .DEPTH_LOG2(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enabled(enabled),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cap(input int p,
                         input int lvl,
                         input bit rising);
    bus.pretrig     = 4'(p);
    bus.trig_level  = 16'(lvl);
    bus.trig_rising = rising;
    bus.arm         = 1'b1;
    tick();
    bus.arm         = 1'b0;
  endtask

  // one strobe every 3rd cycle
  task automatic send(input int v,
                      input bit f = 1'b0);
    bus.sample_in    = 16'(v);
    bus.sample_valid = 1'b1;
    bus.force_trig   = f;
    tick();
    trig_w           = bus.triggered;
    bus.sample_valid = 1'b0;
    bus.force_trig   = 1'b0;
    tick();
    tick();
  endtask

  task automatic read_window(input int pause_at);
    for (int i = 0; i < 16; i++) begin
      bus.rd_en = 1'b1;
      tick();
      check("rd_valid", bus.rd_valid, 1);
      check($sformatf("rd_data[%0d]", i),
            $signed(bus.rd_data), exp_w[i]);
      if (i == pause_at) begin
        enabled = 1'b0;
        repeat (10) tick();
        check("frz_valid", bus.rd_valid, 1);
        check("frz_data", $signed(bus.rd_data),
              exp_w[i]);
        enabled = 1'b1;
      end
    end
    bus.rd_en = 1'b0;
    check("done_last_rd", bus.done, 1);
    tick();
    check("rd_valid_end", bus.rd_valid, 0);
    check("done_clr", bus.done, 0);
    check("trig_clr", bus.triggered, 0);
    check("busy_end", bus.busy, 0);
  endtask

  initial begin
    n_chk            = 0;
    n_fail           = 0;
    trig_w           = 1'b0;
    rst_n            = 1'b0;
    enabled          = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.arm          = 1'b0;
    bus.trig_level   = '0;
    bus.trig_rising  = 1'b1;
    bus.force_trig   = 1'b0;
    bus.pretrig      = '0;
    bus.rd_en        = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_trig", bus.triggered, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", $signed(bus.rd_data), 0);
    rst_n = 1'b1;
    tick();

    // rising trigger, level 0, P=4
    arm_cap(4, 0, 1'b1);
    check("t1_busy", bus.busy, 1);
    for (int v = -10; v <= -1; v++) send(v);
    check("t1_no_trig", bus.triggered, 0);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t1_rd_ignored", bus.rd_valid, 0);
    send(0);
    check("t1_trig_1cyc", trig_w, 1);
    for (int v = 1; v <= 10; v++) send(v);
    check("t1_not_done", bus.done, 0);
    send(11);
    check("t1_done", bus.done, 1);
    check("t1_busy_done", bus.busy, 0);
    for (int v = 12; v <= 20; v++) send(v);
    for (int i = 0; i < 16; i++) exp_w[i] = -4 + i;
    read_window(-1);

    // falling trigger, level 100, P=2
    arm_cap(2, 100, 1'b0);
    for (int v = 120; v >= 105; v -= 5) send(v);
    check("t2_no_trig", bus.triggered, 0);
    send(100);
    check("t2_trig", trig_w, 1);
    for (int v = 95; v >= 30; v -= 5) send(v);
    check("t2_done", bus.done, 1);
    for (int i = 0; i < 16; i++) exp_w[i] = 110 - 5 * i;
    read_window(-1);

    // P=0, first sample above level, forced trigger
    arm_cap(0, 0, 1'b1);
    send(50);
    send(51);
    send(52);
    check("t3_no_edge", bus.triggered, 0);
    bus.force_trig = 1'b1;
    tick();
    bus.force_trig = 1'b0;
    tick();
    check("t3_force_wait", bus.triggered, 0);
    send(53);
    check("t3_force_trig", trig_w, 1);
    for (int v = 54; v <= 68; v++) send(v);
    check("t3_done", bus.done, 1);
    for (int i = 0; i < 16; i++) exp_w[i] = 53 + i;
    read_window(-1);

    // P=15 (max), crossing inside pre-trigger,
    // force on the same strobe
    arm_cap(15, 0, 1'b1);
    for (int v = -3; v <= 11; v++) send(v);
    check("t4_pre_cross", bus.triggered, 0);
    check("t4_busy", bus.busy, 1);
    send(-1, 1'b1);
    check("t4_force_same", trig_w, 1);
    check("t4_done", bus.done, 1);
    for (int i = 0; i < 15; i++) exp_w[i] = -3 + i;
    exp_w[15] = -1;
    read_window(-1);

    // long wait below level, window wraps
    arm_cap(5, 0, 1'b1);
    for (int i = 0; i < 40; i++) send(-100 + i);
    check("t5_no_trig", bus.triggered, 0);
    send(7);
    check("t5_trig", trig_w, 1);
    for (int v = 8; v <= 17; v++) send(v);
    check("t5_done", bus.done, 1);
    for (int i = 0; i < 5; i++) exp_w[i] = -65 + i;
    for (int i = 5; i < 16; i++) exp_w[i] = 2 + i;
    read_window(-1);

    // arm in POSTTRIG, async reset mid-capture
    arm_cap(2, 0, 1'b1);
    send(-2);
    send(-1);
    send(3);
    check("t6_trig", bus.triggered, 1);
    bus.pretrig = '0;
    bus.arm     = 1'b1;
    tick();
    bus.arm     = 1'b0;
    check("t6_arm_ign_busy", bus.busy, 1);
    check("t6_arm_ign_trig", bus.triggered, 1);
    send(4);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_trig", bus.triggered, 0);
    check("t6_rst_done", bus.done, 0);
    check("t6_rst_valid", bus.rd_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle", bus.busy, 0);

    // readout paused by enabled low
    arm_cap(1, 0, 1'b1);
    send(-5);
    send(-3);
    send(1);
    for (int v = 2; v <= 15; v++) send(v);
    check("t7_done", bus.done, 1);
    exp_w[0] = -3;
    for (int i = 1; i < 16; i++) exp_w[i] = i;
    read_window(4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
